// File: rtl/bin_to_gray.sv
// Binary-to-Gray converter with a single registered output stage and a zero-latency combinational tap.
// Optional macro BIN2GRAY_SELFCHECK_EN adds a decode-and-compare integrity check on check_err.
module bin_to_gray #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] binary_in,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] gray_comb
`ifdef BIN2GRAY_SELFCHECK_EN
  ,
  output logic                  check_err
`endif
);

  logic [DATA_WIDTH-1:0] w_gray;
  logic [DATA_WIDTH-1:0] r_gray;
  logic                  r_valid;

  assign w_gray    = binary_in ^ (binary_in >> 1);
  assign gray_comb = w_gray;

  // Capture only on valid, so X on binary_in while idle never reaches r_gray
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_gray <= w_gray;
      end
    end
  end

  assign gray_out  = r_gray;
  assign out_valid = r_valid;

`ifdef BIN2GRAY_SELFCHECK_EN
  logic [DATA_WIDTH-1:0] r_bin_shadow;
  logic [DATA_WIDTH-1:0] w_dec;
  logic                  r_check_err;

  // Decoded bit i is the XOR of all Gray bits from i up to the MSB
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_dec[i] = ^(r_gray >> i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_shadow <= '0;
      r_check_err  <= 1'b0;
    end else begin
      if (in_valid) begin
        r_bin_shadow <= binary_in;
      end
      r_check_err <= r_valid && (w_dec != r_bin_shadow);
    end
  end

  assign check_err = r_check_err;
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Directed self-checking bench for bin_to_gray: reset, directed vectors, corners, hold,
// exhaustive count with wrap, and a random width sweep at 1, 4, 16 and 32 bits.
module tb_bin_to_gray;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bin8;
  logic        v8;
  logic [7:0]  gout8, gcomb8;
  logic        ov8;

  logic        vw;
  logic [0:0]  b1, go1, gc1;
  logic [3:0]  b4, go4, gc4;
  logic [15:0] b16, go16, gc16;
  logic [31:0] b32, go32, gc32;
  logic        ov1, ov4, ov16, ov32;

`ifdef BIN2GRAY_SELFCHECK_EN
  logic ce8, ce1, ce4, ce16, ce32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bin_to_gray #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .binary_in(bin8), .in_valid(v8),
    .gray_out(gout8), .out_valid(ov8), .gray_comb(gcomb8)
`ifdef BIN2GRAY_SELFCHECK_EN
    , .check_err(ce8)
`endif
  );

  bin_to_gray #(.DATA_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .binary_in(b1), .in_valid(vw),
    .gray_out(go1), .out_valid(ov1), .gray_comb(gc1)
`ifdef BIN2GRAY_SELFCHECK_EN
    , .check_err(ce1)
`endif
  );

  bin_to_gray #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .binary_in(b4), .in_valid(vw),
    .gray_out(go4), .out_valid(ov4), .gray_comb(gc4)
`ifdef BIN2GRAY_SELFCHECK_EN
    , .check_err(ce4)
`endif
  );

  bin_to_gray #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .binary_in(b16), .in_valid(vw),
    .gray_out(go16), .out_valid(ov16), .gray_comb(gc16)
`ifdef BIN2GRAY_SELFCHECK_EN
    , .check_err(ce16)
`endif
  );

  bin_to_gray #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .binary_in(b32), .in_valid(vw),
    .gray_out(go32), .out_valid(ov32), .gray_comb(gc32)
`ifdef BIN2GRAY_SELFCHECK_EN
    , .check_err(ce32)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray_decode8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one word at the falling edge, then sample just after the rising edge
  task automatic step8(input logic [7:0] b, input logic v);
    @(negedge clk);
    bin8 = b;
    v8   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err8();
`ifdef BIN2GRAY_SELFCHECK_EN
    chk("check_err8", 64'(ce8), 64'd0);
`endif
  endtask

  logic [7:0]  dir_in  [5] = '{8'h55, 8'h57, 8'h53, 8'h5B, 8'h73};
  logic [7:0]  dir_exp [5] = '{8'h7F, 8'h7C, 8'h7A, 8'h76, 8'h4A};
  logic [7:0]  cor_in  [4] = '{8'h00, 8'h80, 8'hFF, 8'h01};
  logic [7:0]  cor_exp [4] = '{8'h00, 8'hC0, 8'h80, 8'h01};

  initial begin
    logic [7:0]  prev;
    logic [7:0]  bb;
    logic [31:0] r;
    logic [0:0]  e1;
    logic [3:0]  e4;
    logic [15:0] e16;
    logic [31:0] e32;

    rst_n = 1'b0;
    bin8 = 8'h00; v8 = 1'b0;
    vw = 1'b0; b1 = '0; b4 = '0; b16 = '0; b32 = '0;
    #12;
    chk("reset_gray", 64'(gout8), 64'd0);
    chk("reset_valid", 64'(ov8), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    step8(8'h12, 1'b1);
    chk("pre_reset_gray", 64'(gout8), 64'h1B);
    chk("pre_reset_valid", 64'(ov8), 64'd1);

    // Word 0x34 in flight; reset hits mid-cycle before it can be captured
    @(negedge clk);
    bin8 = 8'h34; v8 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gray", 64'(gout8), 64'd0);
    chk("async_reset_valid", 64'(ov8), 64'd0);
    @(posedge clk);
    #1;
    chk("held_reset_gray", 64'(gout8), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    bin8 = dir_in[0]; v8 = 1'b1;
    @(posedge clk);
    #1;
    chk("first_after_release", 64'(gout8), 64'(dir_exp[0]));
    chk("first_after_release_v", 64'(ov8), 64'd1);

    for (int i = 1; i < 5; i++) begin
      step8(dir_in[i], 1'b1);
      chk("directed_gray", 64'(gout8), 64'(dir_exp[i]));
      chk("directed_valid", 64'(ov8), 64'd1);
      chk_err8();
    end

    for (int i = 0; i < 4; i++) begin
      step8(cor_in[i], 1'b1);
      chk("corner_gray", 64'(gout8), 64'(cor_exp[i]));
      chk("corner_valid", 64'(ov8), 64'd1);
    end

    @(negedge clk);
    bin8 = 8'hAA; v8 = 1'b0;
    #1;
    chk("hold_comb", 64'(gcomb8), 64'hFF);
    @(posedge clk);
    #1;
    chk("hold_gray", 64'(gout8), 64'h01);
    chk("hold_valid", 64'(ov8), 64'd0);
    chk_err8();

    step8(8'bxxxx_xxxx, 1'b0);
    chk("x_idle_gray", 64'(gout8), 64'h01);
    chk("x_idle_valid", 64'(ov8), 64'd0);

    prev = 8'h00;
    for (int n = 0; n <= 256; n++) begin
      bb = 8'(n);
      step8(bb, 1'b1);
      chk("count_gray", 64'(gout8), 64'(bb ^ (bb >> 1)));
      chk("count_decode", 64'(gray_decode8(gout8)), 64'(bb));
      if (n > 0) chk("count_hamming", 64'($countones(gout8 ^ prev)), 64'd1);
      chk_err8();
      prev = gout8;
    end
    step8(8'h00, 1'b0);
    chk_err8();

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = $urandom();
      b1 = r[0:0];
      b4 = r[3:0];
      r = $urandom();
      b16 = r[15:0];
      b32 = $urandom();
      vw = 1'b1;
      e1 = b1;
      e4 = b4 ^ (b4 >> 1);
      e16 = b16 ^ (b16 >> 1);
      e32 = b32 ^ (b32 >> 1);
      #1;
      chk("w1_comb", 64'(gc1), 64'(e1));
      chk("w4_comb", 64'(gc4), 64'(e4));
      @(posedge clk);
      #1;
      chk("w1_gray", 64'(go1), 64'(e1));
      chk("w4_gray", 64'(go4), 64'(e4));
      chk("w16_gray", 64'(go16), 64'(e16));
      chk("w32_gray", 64'(go32), 64'(e32));
      chk("w32_valid", 64'(ov32), 64'd1);
`ifdef BIN2GRAY_SELFCHECK_EN
      chk("w16_check_err", 64'(ce16), 64'd0);
`endif
    end
    @(negedge clk);
    vw = 1'b0;
    b32 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("w32_hold_gray", 64'(go32), 64'(e32));
    chk("w32_hold_valid", 64'(ov32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_gray.md
Name: bin_to_gray

Overview:
- Parameterised binary-to-Gray-code converter with a registered output stage.
- Used ahead of clock-domain crossings, for example on FIFO read/write pointers, and for encoder/counter outputs that need single-bit transitions.
- Accepts one binary word per cycle, qualified by a valid strobe, and presents the Gray-coded word one clock later.

Parameters:
- DATA_WIDTH, 8, width of the binary input and Gray output in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- binary_in  input  DATA_WIDTH  binary word to convert
- in_valid  input  1  binary_in is valid this cycle
- gray_out  output  DATA_WIDTH  registered Gray-coded word
- out_valid  output  1  gray_out holds a freshly converted word
- gray_comb  output  DATA_WIDTH  unregistered Gray code of binary_in, same cycle, for callers needing zero latency

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Conversion rule: gray[i] = bin[i] XOR bin[i+1] for i = 0 to DATA_WIDTH-2.
- MSB rule: gray[DATA_WIDTH-1] = bin[DATA_WIDTH-1].
- Equivalently gray = bin XOR (bin >> 1), with a logical shift.
- DATA_WIDTH = 1: gray_out = binary_in.
- gray_comb: purely combinational from binary_in; it ignores in_valid and rst_n.
- Reset: while rst_n = 0, gray_out = 0 and out_valid = 0, applied immediately without waiting for clk.
- Reset release: the first capture is on the first rising clk edge after rst_n goes high.
- Latency: exactly 1 cycle. On a rising edge with in_valid = 1, gray_out <= gray(binary_in) and out_valid <= 1.
- Hold: on a rising edge with in_valid = 0, gray_out holds its previous value and out_valid <= 0.
- Throughput: one word per cycle. No backpressure, no stall, no internal buffering.
- Back-to-back valid words each appear on consecutive cycles.
- Successive binary values differing by 1 (including wrap from all-ones to 0) produce gray_out values differing in exactly one bit.
- X on binary_in with in_valid = 0 must not propagate to gray_out.
- Reset asserted mid-stream: the in-flight word is discarded, and outputs go to 0 asynchronously.

Optional Feature:
- Macro: BIN2GRAY_SELFCHECK_EN.
- When defined, an extra output check_err (1 bit) is added.
- The block decodes gray_out back to binary: b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i].
- The decoded value is compared with a registered copy of the captured binary_in.
- check_err is registered and asserts for one cycle, one cycle after out_valid, on any mismatch.
- check_err resets to 0 and is low whenever the prior out_valid was 0.
- When not defined, check_err, the decoder and the shadow register are absent. Functionality is otherwise identical.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-cycle with a word in flight -> gray_out = 0x00 and out_valid = 0 immediately; first capture is on the first edge after release.
- Directed sequence (DATA_WIDTH = 8), one word per cycle with in_valid = 1: 0x55, 0x57, 0x53, 0x5B, 0x73 -> gray_out 0x7F, 0x7C, 0x7A, 0x76, 0x4A on the following cycles, out_valid = 1 each cycle.
- Corner values: 0x00 -> 0x00; 0x80 -> 0xC0; 0xFF -> 0x80; 0x01 -> 0x01.
- Hold: in_valid = 0 with binary_in changing to 0xAA -> gray_out holds its last value, out_valid = 0, and gray_comb = 0xFF.
- Exhaustive count 0 to 255 then wrap to 0: every consecutive gray_out pair has Hamming distance 1, and the decoded value equals the input. With BIN2GRAY_SELFCHECK_EN defined, check_err stays 0.
- Width sweep at DATA_WIDTH = 1, 4, 16, 32: random inputs match bin XOR (bin >> 1) with 1-cycle latency; DATA_WIDTH = 1 is pass-through.
